// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the three-requester memory bus arbiter: FSM encoding,
// requester indices and shared bus word field positions.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } arb_state_t;

    localparam int N_REQ = 3;
    localparam logic [1:0] REQ_MEM = 2'd0;
    localparam logic [1:0] REQ_AES = 2'd1;
    localparam logic [1:0] REQ_SHA = 2'd2;

    localparam int BUS_W         = 10;
    localparam int BUS_DATA_LSB  = 0;
    localparam int BUS_DATA_MSB  = 7;
    localparam int BUS_VALID     = 8;
    localparam int BUS_READY     = 9;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == REQ_SHA) ? REQ_MEM : idx + 2'd1;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        case (oh)
            3'b010:  return REQ_AES;
            3'b100:  return REQ_SHA;
            default: return REQ_MEM;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// priority pointer wins, result is one-hot (zero when nothing requests).
module mem_bus_arbiter_rr_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic [N_REQ-1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        case (i_ptr)
            REQ_AES: begin
                if      (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
            end
            REQ_SHA: begin
                if      (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
            end
            default: begin
                if      (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for MEM/AES/SHA onto one shared 10-bit bus word.
// Optional owner-hold watchdog is built only when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner; grant the round-robin winner of in_req
// BUSY  | owner drives the bus until its in_done (or watchdog expiry)
// TURN  | one dead cycle, nothing granted, then back to IDLE
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   in_req,
    input  logic [N_REQ-1:0]   in_done,
    input  logic [N_REQ-1:0]   in_valid,
    input  logic [8*N_REQ-1:0] in_data,
    input  logic               in_bus_ready,
    output logic [N_REQ-1:0]   out_grant,
    output logic [N_REQ-1:0]   out_ready,
    output logic [BUS_W-1:0]   out_bus,
    output logic               out_timeout
);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [1:0]       r_ptr;

    logic [N_REQ-1:0] w_pick;
    logic [1:0]       w_owner_idx;
    logic [7:0]       w_owner_data;
    logic             w_owner_valid;
    logic             w_owner_done;
    logic             w_beat;
    logic             w_timeout;

    mem_bus_arbiter_rr_pick u_rr_pick (
        .i_req   (in_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    assign w_owner_idx   = onehot_to_idx(r_grant);
    assign w_owner_valid = |(in_valid & r_grant);
    assign w_owner_done  = |(in_done & r_grant);
    assign w_beat        = w_owner_valid & in_bus_ready;

    always_comb begin
        case (r_grant)
            3'b001:  w_owner_data = in_data[7:0];
            3'b010:  w_owner_data = in_data[15:8];
            3'b100:  w_owner_data = in_data[23:16];
            default: w_owner_data = 8'h00;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_cnt;

    // r_cnt holds the number of beat-less BUSY cycles already elapsed
    assign w_timeout = (r_state == ST_BUSY) && !w_owner_done && !w_beat &&
                       (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (r_state != ST_BUSY || w_beat) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    // Never true for a legal TIMEOUT_CYCLES; no watchdog in this build.
    assign w_timeout = (TIMEOUT_CYCLES < 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= REQ_MEM;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|in_req) begin
                        r_grant <= w_pick;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_owner_done || w_timeout) begin
                        r_grant <= '0;
                        r_ptr   <= next_idx(w_owner_idx);
                        r_state <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        out_bus = '0;
        if (r_state == ST_BUSY) begin
            out_bus[BUS_DATA_MSB:BUS_DATA_LSB] = w_owner_data;
            out_bus[BUS_VALID]                 = w_owner_valid;
        end
    end

    assign out_grant   = r_grant;
    assign out_ready   = r_grant & {N_REQ{in_bus_ready}};
    assign out_timeout = w_timeout;

endmodule
